// File: rtl/audio_feed_i2c_pkg.sv
// Shared constants and types for the audio_feed I2C byte master.
package audio_feed_i2c_pkg;

  localparam int unsigned DIV_W_DEF       = 16;
  localparam int unsigned CLK_DIV_RST_DEF = 124;

  // Avalon register map
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CMD    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CLKDIV = 2'd3;

  // CMD register bit positions
  localparam int unsigned CMD_START = 0;
  localparam int unsigned CMD_STOP  = 1;
  localparam int unsigned CMD_WR    = 2;
  localparam int unsigned CMD_RD    = 3;
  localparam int unsigned CMD_NACK  = 4;

  // STATUS register bit positions
  localparam int unsigned STAT_BUSY   = 0;
  localparam int unsigned STAT_RX_ACK = 1;
  localparam int unsigned STAT_OVR    = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP
  } state_t;

endpackage

// File: rtl/audio_feed_i2c_tick.sv
// Quarter-bit prescaler: counts 0..div and pulses tick_c on the terminal count.
module audio_feed_i2c_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             reload,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt;

  assign tick_c = en && !hold && (cnt == div);

  // Prescaler counter; frozen while hold is asserted
  always_ff @(posedge clk) begin
    if (reset || reload) begin
      cnt <= '0;
    end else if (en && !hold) begin
      cnt <= tick_c ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/audio_feed_i2c_master.sv
// I2C byte-level master with Avalon-MM control registers.
// Optional macro AUDIO_FEED_I2C_CLK_STRETCH_EN enables slave clock stretching.
module audio_feed_i2c_master
  import audio_feed_i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV_RST = CLK_DIV_RST_DEF,
  parameter int unsigned DIV_W       = DIV_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in,
  input  logic        scl_in
);

  state_t           state, state_d;
  logic [1:0]       qtr, qtr_d;
  logic [2:0]       bit_idx, bit_d;
  logic             scl_d, sda_d;
  logic [7:0]       data, shreg;
  logic [DIV_W-1:0] clkdiv;
  logic             rx_ack, ovr;
  logic             op_stop, op_wr, op_rd, op_nack;
  logic             wr_en_c, busy_c, cmd_go_c, cur_wr_c, tick_c, hold_c;
  logic             unused_bits;

  assign wr_en_c  = chipselect && !write_n;
  assign busy_c   = (state != S_IDLE);
  assign cmd_go_c = wr_en_c && (address == REG_CMD) && !busy_c;
  // Direction of the byte about to start, before the op latches update
  assign cur_wr_c = cmd_go_c ? writedata[CMD_WR] : op_wr;

`ifdef AUDIO_FEED_I2C_CLK_STRETCH_EN
  // A slave holding SCL low during the high phase freezes the prescaler
  assign hold_c      = busy_c && (qtr == 2'd1) && !scl_oe && !scl_in;
  assign unused_bits = ^writedata;
`else
  assign hold_c      = 1'b0;
  assign unused_bits = ^{writedata, scl_in};
`endif

  audio_feed_i2c_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (busy_c),
    .reload(!busy_c),
    .hold  (hold_c),
    .div   (clkdiv),
    .tick_c(tick_c)
  );

  // FSM state and registered pin enables
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      qtr     <= 2'd0;
      bit_idx <= 3'd0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_d;
      qtr     <= qtr_d;
      bit_idx <= bit_d;
      scl_oe  <= scl_d;
      sda_oe  <= sda_d;
    end
  end

  // Next phase sequencing, then pin levels for the upcoming quarter
  always_comb begin
    state_d = state;
    qtr_d   = qtr;
    bit_d   = bit_idx;
    scl_d   = scl_oe;
    sda_d   = sda_oe;
    if (state == S_IDLE) begin
      qtr_d = 2'd0;
      bit_d = 3'd0;
      if (cmd_go_c) begin
        if (writedata[CMD_START])                          state_d = S_START;
        else if (writedata[CMD_WR] || writedata[CMD_RD])   state_d = S_BIT;
        else if (writedata[CMD_STOP])                      state_d = S_STOP;
      end
    end else if (tick_c) begin
      qtr_d = qtr + 2'd1;
      if (qtr == 2'd3) begin
        case (state)
          S_START: state_d = (op_wr || op_rd) ? S_BIT : (op_stop ? S_STOP : S_IDLE);
          S_BIT: begin
            bit_d = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_d = S_ACK;
          end
          S_ACK:   state_d = op_stop ? S_STOP : S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
    case (state_d)
      S_START: begin
        sda_d = (qtr_d != 2'd0);
        scl_d = (qtr_d == 2'd3);
      end
      S_BIT: begin
        scl_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        sda_d = cur_wr_c ? !data[3'd7 - bit_d] : 1'b0;
      end
      S_ACK: begin
        scl_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        sda_d = op_wr ? 1'b0 : !op_nack;
      end
      S_STOP: begin
        sda_d = (qtr_d < 2'd2);
        scl_d = (qtr_d == 2'd0);
      end
      default: ;
    endcase
  end

  // Register file, RX shift register and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      data    <= 8'd0;
      shreg   <= 8'd0;
      clkdiv  <= DIV_W'(CLK_DIV_RST);
      rx_ack  <= 1'b0;
      ovr     <= 1'b0;
      op_stop <= 1'b0;
      op_wr   <= 1'b0;
      op_rd   <= 1'b0;
      op_nack <= 1'b0;
    end else begin
      if (wr_en_c) begin
        case (address)
          REG_DATA: data <= writedata[7:0];
          REG_CMD: begin
            if (busy_c) begin
              ovr <= 1'b1;
            end else begin
              op_stop <= writedata[CMD_STOP];
              op_wr   <= writedata[CMD_WR];
              op_rd   <= writedata[CMD_RD] && !writedata[CMD_WR];
              op_nack <= writedata[CMD_NACK];
            end
          end
          REG_STATUS: ovr <= 1'b0;
          default: if (!busy_c) clkdiv <= writedata[DIV_W-1:0];
        endcase
      end
      if (tick_c && (qtr == 2'd1)) begin
        if ((state == S_BIT) && op_rd) shreg <= {shreg[6:0], sda_in};
        if ((state == S_ACK) && op_wr) rx_ack <= sda_in;
      end
      if (tick_c && (qtr == 2'd3) && (state == S_ACK) && op_rd) data <= shreg;
    end
  end

  // Zero-wait read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      REG_DATA:   readdata = 32'(data);
      REG_STATUS: readdata = 32'({ovr, rx_ack, busy_c});
      REG_CLKDIV: readdata = 32'(clkdiv);
      default:    readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_audio_feed_i2c_master.sv
// Randomized bench for audio_feed_i2c_master with an open-drain bus and slave model.
module tb_audio_feed_i2c_master;

  localparam logic [1:0] A_DATA = 2'd0, A_CMD = 2'd1, A_STATUS = 2'd2, A_CLKDIV = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, readdata;
  logic        scl_oe, sda_oe, sda_in, scl_in;
  logic        slave_low, scl_stretch;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc;

  // slave model / bus monitor state
  bit   drv_tab[16];
  bit   rises[$];
  int   rise_cnt;
  bit   stop_seen;
  logic prev_scl = 1'b0, prev_sda = 1'b0;

  // reference model of the register file and bus ownership
  logic [7:0] exp_data;
  bit         exp_rx_ack, exp_ovr, exp_held;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sda_in = !(sda_oe || slave_low);
  assign scl_in = !(scl_oe || scl_stretch);

  audio_feed_i2c_master dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in), .scl_in(scl_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: records SDA at every SCL rise, slave updates its drive on SCL falls
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_scl && !scl_oe) begin
        rises.push_back(sda_in);
        rise_cnt++;
      end
      if (!prev_scl && scl_oe) slave_low = (rise_cnt < 16) ? drv_tab[rise_cnt] : 1'b0;
      if (prev_sda && !sda_oe && !prev_scl && !scl_oe) stop_seen = 1'b1;
    end
    prev_scl = scl_oe;
    prev_sda = sda_oe;
  end

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; address = A_STATUS;
    accept_cyc = cyc;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
    address = A_STATUS;
  endtask

  task automatic wait_idle(input int c0, output int len);
    len = -1;
    address = A_STATUS;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!readdata[0]) begin
        len = cyc - c0;
        break;
      end
    end
  endtask

  task automatic stretch(input int n);
    bit found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (scl_oe) found = 1'b1;
    end
    if (found) begin
      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
        @(negedge clk);
        if (!scl_oe) found = 1'b1;
      end
    end
    check("stretch_wait", 32'(found), 32'd1);
    scl_stretch = 1'b1;
    repeat (n) @(negedge clk);
    scl_stretch = 1'b0;
  endtask

  task automatic run_cmd(input logic [4:0] cmd, input int div, input logic [7:0] tx,
                         input logic [7:0] rx, input bit nak, input bit poke, input int extra);
    bit st, sp, wr, rd, nk, by, act;
    bit expv[16];
    int k, len, c0, exp_len;
    logic [15:0] ev, ov;
    st = cmd[0]; sp = cmd[1]; wr = cmd[2]; rd = cmd[3] && !cmd[2]; nk = cmd[4];
    by = wr || rd; act = st || sp || by;
    av_write(A_CLKDIV, 32'(div));
    av_write(A_DATA, 32'(tx));
    exp_data = tx;
    for (int i = 0; i < 16; i++) begin drv_tab[i] = 1'b0; expv[i] = 1'b0; end
    k = 0;
    if (st && exp_held) begin expv[k] = 1'b1; k++; end
    if (by) begin
      for (int i = 0; i < 8; i++) begin
        expv[k] = wr ? tx[7-i] : rx[7-i];
        drv_tab[k] = rd ? !rx[7-i] : 1'b0;
        k++;
      end
      expv[k] = wr ? nak : nk;
      drv_tab[k] = wr ? !nak : 1'b0;
      k++;
    end
    if (sp) begin expv[k] = 1'b0; k++; end
    rises.delete(); rise_cnt = 0; stop_seen = 1'b0;
    slave_low = exp_held ? drv_tab[0] : 1'b0;
    av_write(A_CMD, 32'(cmd));
    c0 = accept_cyc;
    if (poke) begin
      av_write(A_CMD, 32'h1F);
      exp_ovr = 1'b1;
      @(negedge clk);
      check("ovr_set", 32'(readdata[2]), 32'd1);
    end
    if (extra > 0) stretch(extra);
    exp_len = act ? (4 * int'(st) + 36 * int'(by) + 4 * int'(sp)) * (div + 1) + extra : 0;
    wait_idle(c0, len);
    check("busy_len", 32'(len), 32'(exp_len));
    check("rise_cnt", 32'(rises.size()), 32'(k));
    ev = '0; ov = '0;
    for (int i = 0; i < 16; i++) begin
      ev[i] = expv[i];
      if (i < rises.size()) ov[i] = rises[i];
    end
    check("sda_bits", 32'(ov), 32'(ev));
    if (wr) exp_rx_ack = nak;
    if (rd) exp_data = rx;
    if (act) exp_held = !sp;
    read_check("status", A_STATUS, 32'({exp_ovr, exp_rx_ack, 1'b0}));
    read_check("data", A_DATA, 32'(exp_data));
    check("scl_held", 32'(scl_oe), 32'(exp_held));
    if (sp) begin
      check("stop_seen", 32'(stop_seen), 32'd1);
      check("sda_rel", 32'(sda_oe), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] cmd;
    reset = 1'b1; address = A_DATA; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    slave_low = 1'b0; scl_stretch = 1'b0;
    exp_data = 8'd0; exp_rx_ack = 1'b0; exp_ovr = 1'b0; exp_held = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    read_check("rst_data", A_DATA, 32'd0);
    read_check("rst_status", A_STATUS, 32'd0);
    read_check("rst_clkdiv", A_CLKDIV, 32'd124);
    check("rst_scl", 32'(scl_oe), 32'd0);
    check("rst_sda", 32'(sda_oe), 32'd0);

    // START+WR+STOP of 0x34, slave ACKs
    run_cmd(5'h07, 3, 8'h34, 8'h00, 1'b0, 1'b0, 0);
    // RD+NACK+STOP, slave returns 0xA5
    run_cmd(5'h1A, 3, 8'h00, 8'hA5, 1'b0, 1'b0, 0);
    // CMD while busy sets ovr, STATUS write clears it
    run_cmd(5'h07, 3, 8'h5C, 8'h00, 1'b0, 1'b1, 0);
    av_write(A_STATUS, 32'd0);
    exp_ovr = 1'b0;
    read_check("ovr_clr", A_STATUS, 32'({exp_ovr, exp_rx_ack, 1'b0}));
    // START+WR without STOP, slave NACKs: bus is kept
    run_cmd(5'h05, 3, 8'hC3, 8'h00, 1'b1, 1'b0, 0);
    // empty command is a no-op
    run_cmd(5'h00, 2, 8'h11, 8'h00, 1'b0, 1'b0, 0);

    for (int t = 0; t < 14; t++) begin
      cmd = 5'($urandom_range(1, 31));
      if (cmd[3:0] == 4'd0) cmd[1] = 1'b1;
      run_cmd(cmd, int'($urandom_range(0, 4)), 8'($urandom), 8'($urandom),
              1'($urandom), 1'b0, 0);
    end

`ifdef AUDIO_FEED_I2C_CLK_STRETCH_EN
    run_cmd(5'h06, 3, 8'h96, 8'h00, 1'b0, 1'b0, 20);
`endif

    // reset in the middle of a byte
    av_write(A_CLKDIV, 32'd3);
    av_write(A_DATA, 32'h3C);
    rises.delete(); rise_cnt = 0;
    for (int i = 0; i < 16; i++) drv_tab[i] = 1'b0;
    av_write(A_CMD, 32'h07);
    repeat (60) @(posedge clk);
    #1;
    check("busy_pre_rst", 32'(readdata[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_scl", 32'(scl_oe), 32'd0);
    check("mid_rst_sda", 32'(sda_oe), 32'd0);
    check("mid_rst_busy", 32'(readdata[0]), 32'd0);
    reset = 1'b0;
    slave_low = 1'b0;
    exp_data = 8'd0; exp_rx_ack = 1'b0; exp_ovr = 1'b0; exp_held = 1'b0;
    read_check("mid_rst_clkdiv", A_CLKDIV, 32'd124);
    read_check("mid_rst_data", A_DATA, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
